// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: frame-level command controller behind the UART receiver.
// Decodes write / read / ALU command frames from the received byte stream,
// issues register-file and ALU strobes, gates the ALU clock while an ALU
// command is in flight, and pushes results into the TX FIFO.
module rx_cmd_ctrl #(
  parameter int         ADDR_W      = 4,
  parameter int         TIMEOUT     = 1023,
  parameter logic [7:0] CMD_WR      = 8'hAA,
  parameter logic [7:0] CMD_RD      = 8'hBB,
  parameter logic [7:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [7:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              RX_PAR_ERR,
  input  logic              RX_STP_ERR,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic              RF_WR_EN,
  output logic [7:0]        RF_WR_DATA,
  output logic              RF_RD_EN,
  input  logic [7:0]        RF_RD_DATA,
  input  logic              RF_RD_VLD,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  input  logic [15:0]       ALU_OUT,
  input  logic              ALU_OUT_VLD,
  output logic              CLK_GATE_EN,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_FULL,
  output logic              FRAME_ERR
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OPA, OPB, FUN, ALU_WAIT, TX_B0, TX_B1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  // A read result is parked in the upper byte so TX_B1 always sends result[15:8].
  logic [15:0]      result;
  logic             rx_err;
  logic             step;

  assign rx_err = RX_PAR_ERR | RX_STP_ERR;

  // The event that advances a framed state: a result in the wait states, a byte otherwise.
  always_comb begin
    step = RX_D_VLD;
    if (state == RD_WAIT)       step = RF_RD_VLD;
    else if (state == ALU_WAIT) step = ALU_OUT_VLD;
  end

  // Frame sequencer with registered strobes, timeout and abort handling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      result      <= '0;
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      RF_RD_EN    <= 1'b0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      FRAME_ERR   <= 1'b0;
    end else begin
      RF_WR_EN  <= 1'b0;
      RF_RD_EN  <= 1'b0;
      ALU_EN    <= 1'b0;
      TX_D_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state <= WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              state <= RD_ADDR;
            end else if (RX_P_DATA == CMD_ALU_OP) begin
              state       <= OPA;
              CLK_GATE_EN <= 1'b1;
            end else if (RX_P_DATA == CMD_ALU_NOP) begin
              state       <= FUN;
              CLK_GATE_EN <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
          end
        end
        TX_B0: begin
          tmo_cnt <= '0;
          if (RX_D_VLD) FRAME_ERR <= 1'b1;
          if (!TX_FULL) begin
            TX_D_VLD  <= 1'b1;
            TX_P_DATA <= result[7:0];
            state     <= TX_B1;
          end
        end
        TX_B1: begin
          tmo_cnt <= '0;
          if (RX_D_VLD) FRAME_ERR <= 1'b1;
          // Skip a cycle after a push so TX_D_VLD never stays high two cycles
          // and the FIFO full flag has caught up with the previous byte.
          if (!TX_FULL && !TX_D_VLD) begin
            TX_D_VLD  <= 1'b1;
            TX_P_DATA <= result[15:8];
            state     <= IDLE;
          end
        end
        default: begin
          if (rx_err) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            FRAME_ERR   <= 1'b1;
            CLK_GATE_EN <= 1'b0;
          end else begin
            if ((state == RD_WAIT || state == ALU_WAIT) && RX_D_VLD) FRAME_ERR <= 1'b1;
            if (step) begin
              tmo_cnt <= '0;
              case (state)
                WR_ADDR: begin
                  RF_ADDR <= RX_P_DATA[ADDR_W-1:0];
                  state   <= WR_DATA;
                end
                WR_DATA: begin
                  RF_WR_EN   <= 1'b1;
                  RF_WR_DATA <= RX_P_DATA;
                  state      <= IDLE;
                end
                RD_ADDR: begin
                  RF_RD_EN <= 1'b1;
                  RF_ADDR  <= RX_P_DATA[ADDR_W-1:0];
                  state    <= RD_WAIT;
                end
                RD_WAIT: begin
                  result <= {RF_RD_DATA, 8'h00};
                  state  <= TX_B1;
                end
                OPA: begin
                  RF_WR_EN   <= 1'b1;
                  RF_ADDR    <= '0;
                  RF_WR_DATA <= RX_P_DATA;
                  state      <= OPB;
                end
                OPB: begin
                  RF_WR_EN   <= 1'b1;
                  RF_ADDR    <= ADDR_W'(1);
                  RF_WR_DATA <= RX_P_DATA;
                  state      <= FUN;
                end
                FUN: begin
                  ALU_EN  <= 1'b1;
                  ALU_FUN <= RX_P_DATA[3:0];
                  state   <= ALU_WAIT;
                end
                ALU_WAIT: begin
                  result      <= ALU_OUT;
                  CLK_GATE_EN <= 1'b0;
                  state       <= TX_B0;
                end
                default: state <= IDLE;
              endcase
            end else if (tmo_cnt == TMO_LAST) begin
              state       <= IDLE;
              tmo_cnt     <= '0;
              FRAME_ERR   <= 1'b1;
              CLK_GATE_EN <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
